multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Parametrised multi-cycle successor to the single-cycle RV32I control unit. It sequences fetch, decode, execute, memory and write-back through an explicit state machine. It handshakes with instruction and data memory and drives the existing datapath control fields using the same encodings. The block sits between the shared memory port and the datapath, and owns the instruction register.

## Interface
- ALUOP_W, 5: ALUop width; must be ≥4.
- STATUS_W, 4: status width; bit0 Z, bit1 N, bit2 C (1 = no borrow), bit3 V; must be ≥4.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  instruction word from instruction memory.
- instr_valid  in  1  instr is valid this cycle.
- mem_ready  in  1  data access completes this cycle.
- status  in  STATUS_W  ALU flags.
- ifetch_req  out  1  instruction fetch request.
- dmem_req  out  1  data memory request.
- ir  out  32  latched instruction register.
- regRW, ALUsrc, mRW, wb, pcsrc  out  1 each  legacy meanings: ALUsrc 0=imm/1=B; wb 1=from RAM; pcsrc 0=branch/1=next.
- immsrc  out  2  00 I, 01 S, 10 B, 11 J.
- ALUop  out  ALUOP_W  ADD 0, SUB 1, XOR 2, AND 3, OR 4, SLL 6, SRL 7, SRA 8, SLT 9, SLTU 10.
- pc_en  out  1  PC update strobe.
- illegal  out  1  sticky trap flag.

## Operation
- The state register drives all outputs together with the decoded fields latched at DECODE. There is no combinational path from instr, status or mem_ready to any output.
- States: FETCH, DECODE, EXEC, MEM, BR, WB, TRAP.
- **FETCH**
  - ifetch_req=1.
  - On instr_valid: ir<=instr, go to DECODE. Otherwise stay.
- **DECODE**
  - Latch the control fields.
  - Unknown opcode or funct3/funct7 combination goes to TRAP.
  - For R-type funct3 000, funct7 must be 0000000 (ADD) or 0100000 (SUB). Any other value is illegal.
- **EXEC**
  - ALUsrc and ALUop are valid.
  - R/I/JAL go to WB. LW/SW go to MEM. Branches go to BR, and status is captured into the flag register at the end of EXEC.
- **MEM**
  - dmem_req=1. For SW, mRW=1 and is held until mem_ready.
  - On mem_ready: LW goes to WB, SW goes to FETCH with pc_en=1 and pcsrc=1.
- **BR**
  - pcsrc is taken from the latched flags; pc_en=1.
  - BEQ is taken on Z, BNE on !Z.
  - Then go to FETCH.
- **WB**
  - regRW=1 for exactly one cycle. wb=1 for LW only. pc_en=1.
  - pcsrc=0 for JAL, 1 otherwise.
  - Then go to FETCH.
- **TRAP**
  - illegal=1, all strobes 0.
  - The block stays in TRAP until rst.
- I-type ADDI asserts regRW. Every I/R arithmetic op writes back.
- SRLI/SRAI are selected by ir[30]; SRL/SRA by funct7[5].

## Timing
- Reset:
  - State goes to FETCH; ir=0.
  - regRW=0, mRW=0, wb=0, dmem_req=0, pc_en=0, illegal=0.
  - ifetch_req=0 in the cycle rst is high.
  - pcsrc=1, ALUsrc=1, immsrc=00, ALUop=0.
- Zero-wait latency in cycles from FETCH entry to the next FETCH: R/I 4, JAL 4, branch 4, SW 4, LW 5.
- Each wait cycle on instr_valid or mem_ready adds one cycle.
- instr_valid and mem_ready are ignored unless the matching request is asserted.
- rst asserted in any state, including mid-MEM or TRAP, aborts the operation next edge. No strobe fires in that cycle.
- pc_en and regRW are single-cycle pulses. They never overlap mRW.

## Configuration
- CU_BRANCH_EXT_EN defined: BLT (N^V), BGE (!(N^V)), BLTU (!C) and BGEU (C) are decoded, using ALUop SUB and immsrc 10.
- Undefined: branch funct3 100–111 go to TRAP.

## Structure
- Package cu_pkg holds:
  - opcode constants
  - ALUop codes
  - immsrc codes
  - the state enum
  - the status bit indices
- Sub-module cu_decoder is a purely combinational map from ir to control fields plus an illegal bit. It is instantiated once, and its outputs are registered at DECODE.

## Test plan
- ADD x3,x1,x2 (0x002081B3), instr_valid immediate → DECODE/EXEC/WB. ALUop=0, ALUsrc=1, regRW pulse at cycle 4, pc_en pulse.
- LW 0x0000A183 with mem_ready delayed 3 cycles → dmem_req held 3 cycles, then WB with wb=1 and regRW=1. Total 8 cycles.
- BEQ 0x00208463 with status=4'b0001 → BR: pcsrc=0, pc_en=1. Repeat with status=0 → pcsrc=1.
- SW 0x0020A223 → immsrc=01, mRW=1 through MEM, regRW never asserted.
- Opcode 0x7F, then ADD funct7=0x01 → illegal=1 and sticky. rst for one cycle → illegal=0, FETCH.
- BLT funct3 100, status N=1 V=0 → with macro: pcsrc=0. Without macro: illegal=1.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared constants, decoded-control struct and state enum for the multi-cycle RV32I control unit.
// The extended branch set is enabled by defining CU_BRANCH_EXT_EN.
package cu_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam int ST_Z = 0;
  localparam int ST_N = 1;
  localparam int ST_C = 2;
  localparam int ST_V = 3;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_BR, S_WB, S_TRAP
  } cu_state_e;

  typedef struct packed {
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jal;
    logic [2:0] br_f3;
    logic       alu_src;
    logic [1:0] imm_src;
    logic [3:0] alu_op;
  } cu_ctrl_t;

  localparam cu_ctrl_t CTRL_RST = '{alu_src: 1'b1, default: '0};

  // Branch condition from latched flags; C=1 means no borrow (a >= b unsigned).
  function automatic logic branch_taken(input logic [2:0] f3, input logic [3:0] fl);
    case (f3)
      3'b000:  return fl[ST_Z];
      3'b001:  return !fl[ST_Z];
      3'b100:  return fl[ST_N] ^ fl[ST_V];
      3'b101:  return !(fl[ST_N] ^ fl[ST_V]);
      3'b110:  return !fl[ST_C];
      3'b111:  return fl[ST_C];
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/multicycle_control_unit_if.sv
// Memory-side handshake bundle of the multi-cycle control unit.
// A request (ifetch_req / dmem_req) stays high until the matching completion (instr_valid / mem_ready)
// is seen in the same cycle; completions while the request is low are ignored.
interface multicycle_control_unit_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        mem_ready;
  logic        ifetch_req;
  logic        dmem_req;

  modport master (output ifetch_req, dmem_req, input instr, instr_valid, mem_ready);
  modport slave  (input ifetch_req, dmem_req, output instr, instr_valid, mem_ready);
endinterface

// File: rtl/cu_decoder.sv
// Purely combinational map from the instruction register to control fields plus an illegal flag.
// Branch funct3 100-111 decode only when CU_BRANCH_EXT_EN is defined.
module cu_decoder
  import cu_pkg::*;
(
  input  logic [31:0] ir,
  output cu_ctrl_t    ctrl,
  output logic        illegal
);
  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic       unused_fields;

  assign opcode        = ir[6:0];
  assign f3            = ir[14:12];
  assign f7            = ir[31:25];
  assign unused_fields = ^{ir[24:15], ir[11:7]};

  always_comb begin
    ctrl       = CTRL_RST;
    ctrl.br_f3 = f3;
    illegal    = 1'b0;
    case (opcode)
      OP_R, OP_I: begin
        ctrl.alu_src = (opcode == OP_R);
        case (f3)
          3'b000: ctrl.alu_op = (opcode == OP_R && f7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
          3'b001: ctrl.alu_op = ALU_SLL;
          3'b010: ctrl.alu_op = ALU_SLT;
          3'b011: ctrl.alu_op = ALU_SLTU;
          3'b100: ctrl.alu_op = ALU_XOR;
          3'b101: ctrl.alu_op = ir[30] ? ALU_SRA : ALU_SRL;
          3'b110: ctrl.alu_op = ALU_OR;
          default: ctrl.alu_op = ALU_AND;
        endcase
        // funct7 is an immediate for I-type except on shifts.
        if (opcode == OP_R || f3 == 3'b001 || f3 == 3'b101) begin
          if (f3 == 3'b000 || f3 == 3'b101)
            illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
          else
            illegal = (f7 != 7'b0000000);
          if (opcode == OP_I && f3 == 3'b000) illegal = 1'b0;
        end
      end
      OP_LOAD: begin
        ctrl.is_load = 1'b1;
        ctrl.alu_src = 1'b0;
        illegal      = (f3 != 3'b010);
      end
      OP_STORE: begin
        ctrl.is_store = 1'b1;
        ctrl.alu_src  = 1'b0;
        ctrl.imm_src  = IMM_S;
        illegal       = (f3 != 3'b010);
      end
      OP_BRANCH: begin
        ctrl.is_branch = 1'b1;
        ctrl.alu_op    = ALU_SUB;
        ctrl.imm_src   = IMM_B;
`ifdef CU_BRANCH_EXT_EN
        illegal = (f3 == 3'b010) || (f3 == 3'b011);
`else
        illegal = (f3 != 3'b000) && (f3 != 3'b001);
`endif
      end
      OP_JAL: begin
        ctrl.is_jal  = 1'b1;
        ctrl.alu_src = 1'b0;
        ctrl.imm_src = IMM_J;
      end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/BR/WB/TRAP sequencer owning the instruction register.
// Optional macro CU_BRANCH_EXT_EN adds BLT/BGE/BLTU/BGEU.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int ALUOP_W  = 5,
  parameter int STATUS_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  multicycle_control_unit_if.master mem,
  input  logic [STATUS_W-1:0]       status,
  output logic [31:0]               ir,
  output logic                      regRW,
  output logic                      ALUsrc,
  output logic                      mRW,
  output logic                      wb,
  output logic                      pcsrc,
  output logic [1:0]                immsrc,
  output logic [ALUOP_W-1:0]        ALUop,
  output logic                      pc_en,
  output logic                      illegal,
  output cu_state_e                 state_dbg
);
  cu_state_e           state_q, state_d;
  logic [31:0]         ir_q, ir_d;
  cu_ctrl_t            ctrl_q, ctrl_d, dec_ctrl;
  logic [STATUS_W-1:0] flags_q, flags_d;
  logic                st_pc_q, st_pc_d;
  logic                dec_illegal;

  cu_decoder u_dec (.ir(ir_q), .ctrl(dec_ctrl), .illegal(dec_illegal));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      ctrl_q  <= CTRL_RST;
      flags_q <= '0;
      st_pc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ctrl_q  <= ctrl_d;
      flags_q <= flags_d;
      st_pc_q <= st_pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    ctrl_d  = ctrl_q;
    flags_d = flags_q;
    st_pc_d = 1'b0;
    case (state_q)
      S_FETCH: if (mem.instr_valid) begin
        ir_d    = mem.instr;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ctrl_d  = dec_ctrl;
        state_d = dec_illegal ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        if (ctrl_q.is_branch) begin
          flags_d = status;
          state_d = S_BR;
        end else if (ctrl_q.is_load || ctrl_q.is_store) state_d = S_MEM;
        else state_d = S_WB;
      end
      // A store's PC advance is deferred to the first FETCH cycle so it never
      // overlaps mRW and does not depend combinationally on mem_ready.
      S_MEM: if (mem.mem_ready) begin
        state_d = ctrl_q.is_load ? S_WB : S_FETCH;
        st_pc_d = ctrl_q.is_store;
      end
      S_BR, S_WB: state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    mem.ifetch_req = 1'b0;
    mem.dmem_req   = 1'b0;
    regRW          = 1'b0;
    mRW            = 1'b0;
    wb             = 1'b0;
    pc_en          = 1'b0;
    pcsrc          = 1'b1;
    illegal        = 1'b0;
    ALUsrc         = ctrl_q.alu_src;
    immsrc         = ctrl_q.imm_src;
    ALUop          = ALUOP_W'(ctrl_q.alu_op);
    if (rst) begin
      ALUsrc = 1'b1;
      immsrc = IMM_I;
      ALUop  = '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          mem.ifetch_req = 1'b1;
          pc_en          = st_pc_q;
        end
        S_MEM: begin
          mem.dmem_req = 1'b1;
          mRW          = ctrl_q.is_store;
        end
        S_BR: begin
          pc_en = 1'b1;
          pcsrc = !branch_taken(ctrl_q.br_f3, flags_q[3:0]);
        end
        S_WB: begin
          regRW = 1'b1;
          wb    = ctrl_q.is_load;
          pc_en = 1'b1;
          pcsrc = !ctrl_q.is_jal;
        end
        S_TRAP:  illegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign ir        = ir_q;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-instruction cycle counts, strobe pulses and trap behaviour.
module tb_multicycle_control_unit;
  import cu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  status = '0;
  logic [31:0] ir;
  logic        regRW, ALUsrc, mRW, wb, pcsrc, pc_en, illegal;
  logic [1:0]  immsrc;
  logic [4:0]  ALUop;
  cu_state_e   state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int n_regrw, regrw_at, n_pcen, pcsrc_at_pcen, n_mrw, n_wb, n_dwait, n_overlap;
  int cyc;
  bit tmo;

  multicycle_control_unit_if bus ();

  multicycle_control_unit #(.ALUOP_W(5), .STATUS_W(4)) dut (
    .clk(clk), .rst(rst), .mem(bus.master), .status(status), .ir(ir),
    .regRW(regRW), .ALUsrc(ALUsrc), .mRW(mRW), .wb(wb), .pcsrc(pcsrc),
    .immsrc(immsrc), .ALUop(ALUop), .pc_en(pc_en), .illegal(illegal),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sample_strobes(input int c);
    if (regRW) begin n_regrw++; regrw_at = c; end
    if (pc_en) begin n_pcen++; pcsrc_at_pcen = int'(pcsrc); end
    if (mRW) n_mrw++;
    if (wb) n_wb++;
    if ((pc_en || regRW) && mRW) n_overlap++;
  endtask

  // Starts at a negedge with the DUT in FETCH; returns at the negedge of the next FETCH.
  task automatic run_instr(input logic [31:0] w, input logic [3:0] st, input int fwait,
                           input int mwait, output int cycles, output bit timed_out);
    bit delivered = 0, left = 0;
    int fw = fwait, mw = mwait;
    n_regrw = 0; regrw_at = 0; n_pcen = 0; pcsrc_at_pcen = -1;
    n_mrw = 0; n_wb = 0; n_dwait = 0; n_overlap = 0;
    cycles = 0; timed_out = 1;
    for (int n = 0; n < 40; n++) begin
      cycles++;
      if (n > 0) sample_strobes(cycles);
      if (delivered && !bus.ifetch_req) left = 1;
      bus.instr_valid = 1'b0;
      bus.mem_ready   = 1'b0;
      status          = st;
      if (bus.ifetch_req && !delivered) begin
        if (fw > 0) fw--;
        else begin bus.instr = w; bus.instr_valid = 1'b1; delivered = 1; end
      end
      if (bus.dmem_req) begin
        if (mw > 0) begin mw--; n_dwait++; end
        else bus.mem_ready = 1'b1;
      end
      @(negedge clk);
      if (left && bus.ifetch_req) begin
        sample_strobes(cycles + 1);
        timed_out = 0;
        break;
      end
    end
    bus.instr_valid = 1'b0;
    bus.mem_ready   = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.mem_ready   = 1'b0;
    @(negedge clk);
    chk_eq({tag, "_in_rst_strobes"},
           {bus.ifetch_req, bus.dmem_req, regRW, mRW, wb, pc_en, illegal}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk_eq({tag, "_ir"}, ir, 32'h0);
    chk_eq({tag, "_ifetch"}, bus.ifetch_req, 1);
    chk_eq({tag, "_strobes"}, {bus.dmem_req, regRW, mRW, wb, pc_en, illegal}, 32'h0);
    chk_eq({tag, "_fields"}, {pcsrc, ALUsrc, immsrc, ALUop}, {1'b1, 1'b1, 2'b00, 5'd0});
  endtask

  initial begin
    bus.instr = '0;
    bus.instr_valid = 1'b0;
    bus.mem_ready = 1'b0;
    do_reset("reset");

    // ADD x3,x1,x2
    run_instr(32'h002081B3, 4'h0, 0, 0, cyc, tmo);
    chk_eq("add_tmo", tmo, 0);
    chk_eq("add_cycles", cyc, 4);
    chk_eq("add_regrw", {n_regrw, regrw_at}, {32'd1, 32'd4});
    chk_eq("add_pcen", n_pcen, 1);
    chk_eq("add_pcsrc", pcsrc_at_pcen, 1);
    chk_eq("add_alu", {ALUsrc, ALUop}, {1'b1, 5'd0});
    chk_eq("add_ir", ir, 32'h002081B3);
    chk_eq("add_mrw_wb", n_mrw + n_wb, 0);

    // LW with three data wait cycles
    run_instr(32'h0000A183, 4'h0, 0, 3, cyc, tmo);
    chk_eq("lw_cycles", cyc, 8);
    chk_eq("lw_dwait", n_dwait, 3);
    chk_eq("lw_wb", n_wb, 1);
    chk_eq("lw_regrw", {n_regrw, regrw_at}, {32'd1, 32'd8});
    chk_eq("lw_fields", {ALUsrc, immsrc}, {1'b0, 2'b00});
    chk_eq("lw_mrw", n_mrw, 0);

    // BEQ taken then not taken
    run_instr(32'h00208463, 4'b0001, 0, 0, cyc, tmo);
    chk_eq("beq_t_cycles", cyc, 4);
    chk_eq("beq_t_pcen", n_pcen, 1);
    chk_eq("beq_t_pcsrc", pcsrc_at_pcen, 0);
    chk_eq("beq_t_regrw", n_regrw, 0);
    chk_eq("beq_fields", {immsrc, ALUop}, {2'b10, 5'd1});
    run_instr(32'h00208463, 4'b0000, 0, 0, cyc, tmo);
    chk_eq("beq_n_pcsrc", pcsrc_at_pcen, 1);

    // SW with two data wait cycles
    run_instr(32'h0020A223, 4'h0, 0, 2, cyc, tmo);
    chk_eq("sw_cycles", cyc, 6);
    chk_eq("sw_immsrc", immsrc, 2'b01);
    chk_eq("sw_mrw", n_mrw, 3);
    chk_eq("sw_regrw", n_regrw, 0);
    chk_eq("sw_pcen", n_pcen, 1);
    chk_eq("sw_pcsrc", pcsrc_at_pcen, 1);
    chk_eq("sw_overlap", n_overlap, 0);

    // SUB with two fetch wait cycles
    run_instr(32'h402081B3, 4'h0, 2, 0, cyc, tmo);
    chk_eq("sub_cycles", cyc, 6);
    chk_eq("sub_aluop", ALUop, 5'd1);

    run_instr(32'h0020B1B3, 4'h0, 0, 0, cyc, tmo);
    chk_eq("sltu_aluop", {ALUsrc, ALUop}, {1'b1, 5'd10});

    run_instr(32'h40315093, 4'h0, 0, 0, cyc, tmo);
    chk_eq("srai_alu", {ALUsrc, ALUop}, {1'b0, 5'd8});
    chk_eq("srai_regrw", n_regrw, 1);

    run_instr(32'h000000EF, 4'h0, 0, 0, cyc, tmo);
    chk_eq("jal_cycles", cyc, 4);
    chk_eq("jal_pcsrc", pcsrc_at_pcen, 0);
    chk_eq("jal_regrw_immsrc", {n_regrw, 30'd0, immsrc}, {32'd1, 30'd0, 2'b11});

    // BLT with N=1 V=0
    run_instr(32'h0020C463, 4'b0010, 0, 0, cyc, tmo);
`ifdef CU_BRANCH_EXT_EN
    chk_eq("blt_tmo", tmo, 0);
    chk_eq("blt_pcsrc", pcsrc_at_pcen, 0);
`else
    chk_eq("blt_trap", {tmo, illegal}, 2'b11);
    chk_eq("blt_pcen", n_pcen, 0);
`endif
    do_reset("blt_reset");

    // Unknown opcode: trap is sticky and silent until reset
    run_instr(32'h0000007F, 4'h0, 0, 0, cyc, tmo);
    chk_eq("op7f_stuck", tmo, 1);
    chk_eq("op7f_illegal", illegal, 1);
    chk_eq("op7f_strobes", {bus.ifetch_req, bus.dmem_req, regRW, mRW, pc_en}, 32'h0);
    chk_eq("op7f_counts", n_pcen + n_regrw + n_mrw, 0);
    do_reset("op7f_reset");

    run_instr(32'h022081B3, 4'h0, 0, 0, cyc, tmo);
    chk_eq("f7bad_trap", {tmo, illegal}, 2'b11);
    chk_eq("f7bad_counts", n_pcen + n_regrw, 0);
    do_reset("f7bad_reset");

    run_instr(32'h002081B3, 4'h0, 0, 0, cyc, tmo);
    chk_eq("post_reset_add", {tmo, cyc[7:0]}, {1'b0, 8'd4});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
